core_launcher: RTL and testbench
================================

# core_launcher

Host-side initiator for the processor core's `req`/`done` run protocol. It accepts a run request from the host or bench and resets the core for a fixed number of cycles. It then issues a single-cycle `req`, waits for the rising edge of the core's `done`, and reports status and cycle count. A watchdog timeout and a host abort path are included. It sits between the host or bench and the core top level, and drives the core's `reset` and `req` inputs.

## Interface
- `RST_CYCLES`, default 2: cycles `core_reset` is held high at the start of each run (≥1).
- `CW`, default 16: width of the cycle counter.
- `TIMEOUT`, default 50000: maximum cycles after `req` before the run is abandoned (≤ 2^CW−1).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low block reset.
- `start`  in  1  run request; accepted only while `ready`=1.
- `abort`  in  1  cancels an in-progress run; ignored in IDLE.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in RST, REQ and WAIT.
- `core_reset`  out  1  active-high reset to the core.
- `core_req`  out  1  run request to the core; one-cycle pulse.
- `core_done`  in  1  core completion flag (level).
- `result_valid`  out  1  one-cycle pulse when a run ends.
- `status`  out  2  run result: 00 none, 01 ok, 10 timeout, 11 aborted.
- `cycles`  out  CW  cycles from `core_req` to completion.
- `run_count`  out  8  number of successful runs; wraps from 255 to 0.

## Operation
- **FSM states:** IDLE, RST, REQ, WAIT, DONE.
- **IDLE:**
  - `start`=1 → RST.
  - Load the reset counter with RST_CYCLES.
  - Set `core_reset`=1.
  - Clear `status` to 00.
- **RST:**
  - Counter decrements each cycle.
  - When the last cycle is reached → REQ.
  - Clear `core_reset`.
- **REQ:**
  - `core_req`=1 for exactly this cycle.
  - Clear the cycle counter → WAIT.
- **WAIT:**
  - Cycle counter increments each cycle.
  - Completion is `core_done`=1 while the registered previous value `done_q`=0 (rising edge).
  - On completion → DONE with `status`=01, `cycles` latched, and `run_count`+1.
  - Timeout: no completion by the TIMEOUT-th cycle after REQ → DONE with `status`=10, `cycles`=TIMEOUT, and `core_reset` set to 1.
- **DONE:**
  - `result_valid`=1 for one cycle → IDLE.
  - `status` and `cycles` hold until the next `start` is accepted.
- **Abort:**
  - `abort`=1 in RST, REQ or WAIT → DONE with `status`=11.
  - `core_reset` set to 1; `cycles` latches its current value.
  - `abort` has priority over completion and timeout in the same cycle.
- **Completion vs timeout:** completion has priority when both occur in the same cycle.
- **`start` outside IDLE:** ignored, with no queueing. `start`+`abort` together in IDLE: `start` is accepted.
- **`done_q`:** updates every cycle in every state. A stale-high `core_done` never counts as completion without first being seen low.
- **`core_reset` hold:** stays 1 after block reset until the first run's RST phase ends. After a timeout or abort it stays 1 until the next run's RST ends.

## Timing
- **Reset values (while `reset`=0):**
  - State IDLE.
  - `ready`=1, `busy`=0.
  - `core_reset`=1, `core_req`=0.
  - `result_valid`=0, `status`=00, `cycles`=0, `run_count`=0, `done_q`=0.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- **Run sequence, with `start` sampled high at edge k:**
  - `core_reset`=1 in cycles k+1 … k+RST_CYCLES.
  - `core_req`=1 in cycle r = k+RST_CYCLES+1; `core_reset`=0 from cycle r.
  - If `core_done` is first sampled high (rising) in cycle r+N, N≥1: `cycles`=N, `result_valid`=1 in cycle r+N+1, and `ready`=1 in cycle r+N+2.
  - The earliest next accepted `start` is sampled at the end of cycle r+N+2.
- **Timeout:** `result_valid` in cycle r+TIMEOUT+1. A `core_done` rise in cycle r+TIMEOUT still counts as ok.
- **Cycle counter:** saturates at 2^CW−1 and never wraps.
- **Async reset mid-run:** all state returns to reset values immediately, and `core_reset`=1 within the same cycle.

## Test plan
- RST_CYCLES=2; `start` at edge 0; `core_done` rises 5 cycles after `core_req` → `core_reset` high in cycles 1–2, `core_req` in cycle 3, `result_valid` in cycle 9, `status`=01, `cycles`=5, `run_count`=1.
- TIMEOUT=8; `core_done` held 0 → `result_valid` 9 cycles after `core_req`, `status`=10, `cycles`=8, `core_reset`=1, `run_count` unchanged.
- `abort` 3 cycles into WAIT with `core_done` rising in the same cycle → `status`=11, `cycles`=3, `core_reset`=1, `run_count` unchanged.
- `core_done` stuck high from before `start`, drops 2 cycles after `core_req`, rises again at N=6 → `status`=01, `cycles`=6.
- `start` pulsed during RST and during WAIT → ignored; exactly one `core_req` per accepted run; `ready`=0 throughout.
- `reset` asserted low mid-WAIT → immediately `ready`=1, `core_reset`=1, `status`=00, `cycles`=0. After 256 successful runs → `run_count`=0.

Source files
------------

// File: rtl/core_launcher.sv
// core_launcher: host-side initiator for the core req/done run protocol.
// A run holds core_reset high for RST_CYCLES cycles and then pulses core_req
// for one cycle. It then waits for a rising edge of core_done and reports
// status, cycle count and a running count of successful runs. A run that
// times out or is aborted leaves the core held in reset until the next run.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low block reset
//   start        run request, accepted only while ready
//   abort        cancels a run in RST/REQ/WAIT
//   ready        high in IDLE
//   busy         high in RST, REQ, WAIT
//   core_reset   active-high reset to the core
//   core_req     one-cycle run request to the core
//   core_done    core completion level
//   result_valid one-cycle pulse when a run ends
//   status       00 none, 01 ok, 10 timeout, 11 aborted
//   cycles       cycles from core_req to completion
//   run_count    successful runs, wraps at 256
module core_launcher #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CW         = 16,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          result_valid,
  output logic [1:0]    status,
  output logic [CW-1:0] cycles,
  output logic [7:0]    run_count
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_OK      = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q;
  logic            core_reset_d;
  logic [1:0]      status_d;
  logic [CW-1:0]   cycles_d;
  logic [7:0]      run_count_d;
  logic            ready_d, busy_d, core_req_d, result_valid_d;
  logic [CW-1:0]   elapsed;
  logic            done_rise;

  // Cycles since core_req as seen during the current WAIT cycle (saturating).
  assign elapsed   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  // Only a low-to-high transition counts; a stale-high done never completes.
  assign done_rise = core_done & ~done_q;

  // Next-state and next-value logic for every register.
  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    cnt_d        = cnt_q;
    core_reset_d = core_reset;
    status_d     = status;
    cycles_d     = cycles;
    run_count_d  = run_count;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RST;
          rcnt_d       = RW'(RST_CYCLES);
          cnt_d        = '0;
          core_reset_d = 1'b1;
          status_d     = ST_NONE;
          cycles_d     = '0;
        end
      end

      S_RST: begin
        rcnt_d = rcnt_q - RW'(1);
        if (abort) begin
          state_d      = S_DONE;
          status_d     = ST_ABORT;
          core_reset_d = 1'b1;
          cycles_d     = cnt_q;
        end else if (rcnt_q <= RW'(1)) begin
          state_d      = S_REQ;
          core_reset_d = 1'b0;
        end
      end

      S_REQ: begin
        cnt_d = '0;
        if (abort) begin
          state_d      = S_DONE;
          status_d     = ST_ABORT;
          core_reset_d = 1'b1;
          cycles_d     = '0;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = elapsed;
        if (abort) begin
          state_d      = S_DONE;
          status_d     = ST_ABORT;
          core_reset_d = 1'b1;
          cycles_d     = elapsed;
        end else if (done_rise) begin
          state_d     = S_DONE;
          status_d    = ST_OK;
          cycles_d    = elapsed;
          run_count_d = run_count + 8'd1;
        end else if (elapsed >= CW'(TIMEOUT)) begin
          state_d      = S_DONE;
          status_d     = ST_TIMEOUT;
          core_reset_d = 1'b1;
          cycles_d     = CW'(TIMEOUT);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // State-decoded outputs are registered from the next state.
    ready_d        = (state_d == S_IDLE);
    busy_d         = (state_d == S_RST) || (state_d == S_REQ) || (state_d == S_WAIT);
    core_req_d     = (state_d == S_REQ);
    result_valid_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rcnt_q       <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      ready        <= 1'b1;
      busy         <= 1'b0;
      core_reset   <= 1'b1;
      core_req     <= 1'b0;
      result_valid <= 1'b0;
      status       <= ST_NONE;
      cycles       <= '0;
      run_count    <= '0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      cnt_q        <= cnt_d;
      done_q       <= core_done;
      ready        <= ready_d;
      busy         <= busy_d;
      core_reset   <= core_reset_d;
      core_req     <= core_req_d;
      result_valid <= result_valid_d;
      status       <= status_d;
      cycles       <= cycles_d;
      run_count    <= run_count_d;
    end
  end

endmodule

// File: tb/tb_core_launcher.sv
// Directed bench for core_launcher with RST_CYCLES=2, TIMEOUT=8.
module tb_core_launcher;

  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          ready;
  logic          busy;
  logic          core_reset;
  logic          core_req;
  logic          core_done;
  logic          result_valid;
  logic [1:0]    status;
  logic [CW-1:0] cycles;
  logic [7:0]    run_count;

  int n_cmp;
  int n_fail;
  int req_pulses;

  core_launcher #(.RST_CYCLES(2), .CW(CW), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(rst_n),
    .start(start),
    .abort(abort),
    .ready(ready),
    .busy(busy),
    .core_reset(core_reset),
    .core_req(core_req),
    .core_done(core_done),
    .result_valid(result_valid),
    .status(status),
    .cycles(cycles),
    .run_count(run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (core_req === 1'b1) req_pulses++;

  // Advance n edges; land 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept a start; returns positioned in cycle r (core_req high).
  task automatic launch();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset got %b want 1", core_reset); end
    n_cmp++; if (core_req !== 1'b0) begin n_fail++; $display("FAIL reset_core_req got %b want 0", core_req); end
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid got %b want 0", result_valid); end
    n_cmp++; if ({status, cycles, run_count} !== '0) begin n_fail++; $display("FAIL reset_regs got st=%b cyc=%0d rc=%0d want 0", status, cycles, run_count); end
  endtask

  task automatic test_run_ok();
    start = 1'b1;
    tick(1);                 // cycle 1
    start = 1'b0;
    n_cmp++; if ({core_reset, core_req, busy, ready} !== 4'b1010) begin n_fail++; $display("FAIL ok_c1 got rst/req/busy/rdy=%b want 1010", {core_reset, core_req, busy, ready}); end
    tick(1);                 // cycle 2
    n_cmp++; if ({core_reset, core_req} !== 2'b10) begin n_fail++; $display("FAIL ok_c2 got rst/req=%b want 10", {core_reset, core_req}); end
    tick(1);                 // cycle 3 = r
    n_cmp++; if ({core_reset, core_req} !== 2'b01) begin n_fail++; $display("FAIL ok_c3 got rst/req=%b want 01", {core_reset, core_req}); end
    tick(1);                 // cycle 4
    n_cmp++; if (core_req !== 1'b0) begin n_fail++; $display("FAIL ok_req_width got %b want 0", core_req); end
    tick(4);                 // cycle 8 = r+5
    core_done = 1'b1;
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ok_early_valid got %b want 0", result_valid); end
    tick(1);                 // cycle 9
    n_cmp++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL ok_valid got %b want 1", result_valid); end
    n_cmp++; if (status !== 2'b01) begin n_fail++; $display("FAIL ok_status got %b want 01", status); end
    n_cmp++; if (cycles !== 16'd5) begin n_fail++; $display("FAIL ok_cycles got %0d want 5", cycles); end
    n_cmp++; if (run_count !== 8'd1) begin n_fail++; $display("FAIL ok_run_count got %0d want 1", run_count); end
    tick(1);                 // cycle 10
    core_done = 1'b0;
    n_cmp++; if ({ready, result_valid, status} !== 4'b1001) begin n_fail++; $display("FAIL ok_idle got rdy/rv/st=%b want 1001", {ready, result_valid, status}); end
    n_cmp++; if (cycles !== 16'd5) begin n_fail++; $display("FAIL ok_cycles_hold got %0d want 5", cycles); end
  endtask

  task automatic test_timeout();
    launch();
    tick(8);                 // r+8
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", result_valid); end
    tick(1);                 // r+9
    n_cmp++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL to_valid got %b want 1", result_valid); end
    n_cmp++; if (status !== 2'b10) begin n_fail++; $display("FAIL to_status got %b want 10", status); end
    n_cmp++; if (cycles !== 16'd8) begin n_fail++; $display("FAIL to_cycles got %0d want 8", cycles); end
    n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL to_core_reset got %b want 1", core_reset); end
    n_cmp++; if (run_count !== 8'd1) begin n_fail++; $display("FAIL to_run_count got %0d want 1", run_count); end
    tick(3);
    n_cmp++; if ({core_reset, ready} !== 2'b11) begin n_fail++; $display("FAIL to_hold got rst/rdy=%b want 11", {core_reset, ready}); end
  endtask

  task automatic test_abort();
    launch();
    tick(3);                 // r+3
    abort = 1'b1;
    core_done = 1'b1;
    tick(1);
    abort = 1'b0;
    n_cmp++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL ab_valid got %b want 1", result_valid); end
    n_cmp++; if (status !== 2'b11) begin n_fail++; $display("FAIL ab_status got %b want 11", status); end
    n_cmp++; if (cycles !== 16'd3) begin n_fail++; $display("FAIL ab_cycles got %0d want 3", cycles); end
    n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL ab_core_reset got %b want 1", core_reset); end
    n_cmp++; if (run_count !== 8'd1) begin n_fail++; $display("FAIL ab_run_count got %0d want 1", run_count); end
    tick(1);
    core_done = 1'b0;
    tick(2);
  endtask

  task automatic test_stale_done();
    core_done = 1'b1;
    tick(3);
    launch();                // r
    tick(2);                 // r+2
    core_done = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL stale_counted got %b want 0", result_valid); end
    tick(4);                 // r+6
    core_done = 1'b1;
    tick(1);
    n_cmp++; if ({result_valid, status} !== 3'b101) begin n_fail++; $display("FAIL stale_status got rv/st=%b want 101", {result_valid, status}); end
    n_cmp++; if (cycles !== 16'd6) begin n_fail++; $display("FAIL stale_cycles got %0d want 6", cycles); end
    n_cmp++; if (run_count !== 8'd2) begin n_fail++; $display("FAIL stale_run_count got %0d want 2", run_count); end
    tick(1);
    core_done = 1'b0;
    tick(1);
  endtask

  task automatic test_start_ignored();
    int r0;
    r0 = req_pulses;
    start = 1'b1;
    tick(1);                 // cycle 1, RST
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ign_ready_rst got %b want 0", ready); end
    tick(1);                 // cycle 2, start still high in RST
    start = 1'b0;
    tick(3);                 // r+2, WAIT
    start = 1'b1;
    n_cmp++; if ({ready, busy} !== 2'b01) begin n_fail++; $display("FAIL ign_ready_wait got rdy/busy=%b want 01", {ready, busy}); end
    tick(1);
    start = 1'b0;
    tick(1);                 // r+4
    core_done = 1'b1;
    tick(1);
    n_cmp++; if ({result_valid, status} !== 3'b101) begin n_fail++; $display("FAIL ign_status got rv/st=%b want 101", {result_valid, status}); end
    n_cmp++; if (cycles !== 16'd4) begin n_fail++; $display("FAIL ign_cycles got %0d want 4", cycles); end
    core_done = 1'b0;
    tick(8);
    n_cmp++; if (req_pulses - r0 !== 1) begin n_fail++; $display("FAIL ign_req_count got %0d want 1", req_pulses - r0); end
    n_cmp++; if ({ready, busy} !== 2'b10) begin n_fail++; $display("FAIL ign_idle got rdy/busy=%b want 10", {ready, busy}); end
  endtask

  task automatic test_async_reset();
    launch();
    tick(2);                 // r+2
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({ready, busy, core_reset, core_req} !== 4'b1010) begin n_fail++; $display("FAIL ar_ctrl got rdy/busy/rst/req=%b want 1010", {ready, busy, core_reset, core_req}); end
    n_cmp++; if ({status, cycles, run_count} !== '0) begin n_fail++; $display("FAIL ar_regs got st=%b cyc=%0d rc=%0d want 0", status, cycles, run_count); end
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    n_cmp++; if ({ready, core_reset} !== 2'b11) begin n_fail++; $display("FAIL ar_after got rdy/rst=%b want 11", {ready, core_reset}); end
  endtask

  task automatic test_back_to_back();
    int bound;
    for (int n = 1; n <= 256; n++) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
      bound = 0;
      while (core_req !== 1'b1 && bound < 10) begin tick(1); bound++; end
      if (bound >= 10) begin n_cmp++; n_fail++; $display("FAIL b2b_req_timeout run %0d", n); end
      tick(1);               // r+1
      core_done = 1'b1;
      tick(1);               // DONE
      core_done = 1'b0;
      if (n == 255) begin
        n_cmp++; if (run_count !== 8'd255) begin n_fail++; $display("FAIL b2b_255 got %0d want 255", run_count); end
      end
      bound = 0;
      while (ready !== 1'b1 && bound < 10) begin tick(1); bound++; end
      if (bound >= 10) begin n_cmp++; n_fail++; $display("FAIL b2b_ready_timeout run %0d", n); end
    end
    n_cmp++; if (run_count !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap got %0d want 0", run_count); end
    n_cmp++; if ({status, cycles} !== {2'b01, 16'd1}) begin n_fail++; $display("FAIL b2b_last got st=%b cyc=%0d want 01/1", status, cycles); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    req_pulses = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    core_done = 1'b0;
    tick(3);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    test_reset();
    test_run_ok();
    test_timeout();
    test_abort();
    test_stale_done();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
